// File: rtl/bmu_bitperm_iter_pkg.sv
// Shared issue-interface types and helpers for the iterative BEXT/BDEP unit.
package bmu_bitperm_iter_pkg;

   localparam int unsigned TRANS_ID_BITS = 3;
   localparam int unsigned BMU_CNT_WIDTH = 7;

   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      ANDL = 4'd2,
      ORL  = 4'd3,
      BEXT = 4'd4,
      BDEP = 4'd5
   } fu_op_t;

   typedef struct packed {
      fu_op_t                   operation;
      logic [63:0]              operand_a;
      logic [63:0]              operand_b;
      logic [TRANS_ID_BITS-1:0] trans_id;
   } fu_data_t;

   function automatic logic is_bitperm_op(fu_op_t op);
      logic res;
      case (op)
         BEXT, BDEP: res = 1'b1;
         default:    res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/bmu_lsb_finder.sv
// Combinational lowest-set-bit encoder: isolates the lowest one, then
// ORs it against per-index-bit position masks to form the binary index.
module bmu_lsb_finder
   import bmu_bitperm_iter_pkg::*;
(
   input  logic [63:0] vec,
   output logic [5:0]  lsb_idx,
   output logic        empty
);

   logic [63:0] lsb_onehot_s;

   // Two's-complement isolation of the lowest set bit, then binary encode
   always_comb begin
      lsb_onehot_s = vec & (~vec + 64'd1);
      lsb_idx[0]   = |(lsb_onehot_s & 64'hAAAA_AAAA_AAAA_AAAA);
      lsb_idx[1]   = |(lsb_onehot_s & 64'hCCCC_CCCC_CCCC_CCCC);
      lsb_idx[2]   = |(lsb_onehot_s & 64'hF0F0_F0F0_F0F0_F0F0);
      lsb_idx[3]   = |(lsb_onehot_s & 64'hFF00_FF00_FF00_FF00);
      lsb_idx[4]   = |(lsb_onehot_s & 64'hFFFF_0000_FFFF_0000);
      lsb_idx[5]   = |(lsb_onehot_s & 64'hFFFF_FFFF_0000_0000);
      empty        = (vec == 64'd0);
   end

endmodule

// File: rtl/bmu_bitperm_iter.sv
// Iterative BEXT/BDEP unit: walks the mask one set bit per cycle, building the
// result in an accumulator, then holds it until writeback takes it.
module bmu_bitperm_iter
   import bmu_bitperm_iter_pkg::*;
#(
   parameter bit          EnableBdep = 1'b1,
   parameter int unsigned CntWidth   = BMU_CNT_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  fu_data_t                 fu_data_i,
   input  logic                     bmu_valid_i,
   output logic                     bmu_ready_o,
   output logic [63:0]              result_o,
   output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
   output logic                     result_valid_o,
   input  logic                     result_ready_i,
   output logic                     busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state_r;
   state_t                   state_next_s;
   logic [63:0]              src_r;
   logic [63:0]              mask_r;
   logic [63:0]              acc_r;
   logic [CntWidth-1:0]      k_r;
   fu_op_t                   op_r;
   logic [TRANS_ID_BITS-1:0] trans_id_r;
   logic                     ready_r;
   logic                     valid_r;
   logic                     busy_r;

   logic                     op_supported_s;
   logic [63:0]              mask_init_s;
   logic                     accept_s;
   logic                     step_s;
   logic [5:0]               lsb_idx_s;
   logic                     lsb_empty_s;
   logic [63:0]              lsb_onehot_s;
   logic [63:0]              mask_clr_s;
   logic                     ext_bit_s;
   logic                     dep_bit_s;
   logic [63:0]              acc_step_s;

   bmu_lsb_finder u_lsb_finder (
      .vec     (mask_r),
      .lsb_idx (lsb_idx_s),
      .empty   (lsb_empty_s)
   );

   // Accept decode and one extract/deposit step of the datapath
   always_comb begin
      op_supported_s = is_bitperm_op(fu_data_i.operation) &&
                       ((fu_data_i.operation != BDEP) || EnableBdep);
      if (op_supported_s) begin
         mask_init_s = fu_data_i.operand_b;
      end else begin
         mask_init_s = 64'd0;
      end
      accept_s     = (state_r == IDLE) && bmu_valid_i && !flush_i;
      step_s       = (state_r == BUSY) && !flush_i;
      lsb_onehot_s = 64'd1 << lsb_idx_s;
      mask_clr_s   = mask_r & ~lsb_onehot_s;
      ext_bit_s    = |(src_r & lsb_onehot_s);
      dep_bit_s    = |(src_r & (64'd1 << k_r));
      // BDEP scatters src[k] to the mask position; BEXT gathers src[i] to slot k
      if (op_r == BDEP) begin
         acc_step_s = dep_bit_s ? (acc_r | lsb_onehot_s) : acc_r;
      end else begin
         acc_step_s = acc_r | ({63'd0, ext_bit_s} << k_r);
      end
   end

   // Next-state logic; flush overrides every transition
   always_comb begin
      state_next_s = state_r;
      if (flush_i) begin
         state_next_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_next_s = (mask_init_s != 64'd0) ? BUSY : DONE;
               end else begin
                  state_next_s = IDLE;
               end
            end
            BUSY: begin
               if (lsb_empty_s || (mask_clr_s == 64'd0)) begin
                  state_next_s = DONE;
               end else begin
                  state_next_s = BUSY;
               end
            end
            DONE: begin
               if (result_ready_i) begin
                  state_next_s = IDLE;
               end else begin
                  state_next_s = DONE;
               end
            end
            default: state_next_s = IDLE;
         endcase
      end
   end

   // State register, operand/accumulator registers and registered handshakes
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= IDLE;
         src_r      <= 64'd0;
         mask_r     <= 64'd0;
         acc_r      <= 64'd0;
         k_r        <= '0;
         op_r       <= ADD;
         trans_id_r <= '0;
         ready_r    <= 1'b1;
         valid_r    <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r <= state_next_s;
         ready_r <= (state_next_s == IDLE);
         valid_r <= (state_next_s == DONE);
         busy_r  <= (state_next_s != IDLE);
         if (accept_s) begin
            src_r      <= fu_data_i.operand_a;
            mask_r     <= mask_init_s;
            op_r       <= fu_data_i.operation;
            trans_id_r <= fu_data_i.trans_id;
            k_r        <= '0;
            acc_r      <= 64'd0;
         end else if (step_s) begin
            mask_r <= mask_clr_s;
            k_r    <= k_r + CntWidth'(1);
            acc_r  <= acc_step_s;
         end else begin
            mask_r <= mask_r;
            k_r    <= k_r;
            acc_r  <= acc_r;
         end
      end
   end

   assign bmu_ready_o       = ready_r;
   assign result_valid_o    = valid_r;
   assign busy_o            = busy_r;
   assign result_o          = acc_r;
   assign result_trans_id_o = trans_id_r;

endmodule

// File: tb/tb_bmu_bitperm_iter.sv
// Directed bench for bmu_bitperm_iter with a bit-loop reference model and a
// per-cycle compare process.
module tb_bmu_bitperm_iter;
   import bmu_bitperm_iter_pkg::*;

   logic                     clk_i = 1'b0;
   logic                     rst_i = 1'b1;
   logic                     flush_i = 1'b0;
   fu_data_t                 fu_data_i = '0;
   logic                     bmu_valid_i = 1'b0;
   logic                     bmu_ready_o;
   logic [63:0]              result_o;
   logic [TRANS_ID_BITS-1:0] result_trans_id_o;
   logic                     result_valid_o;
   logic                     result_ready_i = 1'b1;
   logic                     busy_o;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   // reference model state
   logic                     m_busy = 1'b0;
   logic                     m_done = 1'b0;
   int                       m_left = 0;
   logic [63:0]              m_res = 64'd0;
   logic [TRANS_ID_BITS-1:0] m_tid = '0;

   bmu_bitperm_iter dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .flush_i           (flush_i),
      .fu_data_i         (fu_data_i),
      .bmu_valid_i       (bmu_valid_i),
      .bmu_ready_o       (bmu_ready_o),
      .result_o          (result_o),
      .result_trans_id_o (result_trans_id_o),
      .result_valid_o    (result_valid_o),
      .result_ready_i    (result_ready_i),
      .busy_o            (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_result(fu_op_t op, logic [63:0] a, logic [63:0] b);
      logic [63:0] r;
      int k;
      r = 64'd0;
      k = 0;
      for (int i = 0; i < 64; i++) begin
         if (b[i]) begin
            if (op == BEXT) r[k] = a[i];
            else if (op == BDEP) r[i] = a[k];
            k++;
         end
      end
      return r;
   endfunction

   function automatic int model_steps(fu_op_t op, logic [63:0] b);
      return (op == BEXT || op == BDEP) ? $countones(b) : 0;
   endfunction

   // Reference model advanced on every clock edge
   always @(posedge clk_i) begin
      if (rst_i) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
      end else if (flush_i) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
      end else if (m_done) begin
         if (result_ready_i) m_done <= 1'b0;
      end else if (m_busy) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
         end
      end else if (bmu_valid_i) begin
         m_res <= model_result(fu_data_i.operation, fu_data_i.operand_a, fu_data_i.operand_b);
         m_tid <= fu_data_i.trans_id;
         if (model_steps(fu_data_i.operation, fu_data_i.operand_b) == 0) begin
            m_done <= 1'b1;
         end else begin
            m_busy <= 1'b1;
            m_left <= model_steps(fu_data_i.operation, fu_data_i.operand_b);
         end
      end
   end

   // Compare DUT against the model away from the active edge
   always @(negedge clk_i) begin
      if (chk_en) begin
         check("cmp_ready", bmu_ready_o, !(m_busy || m_done));
         check("cmp_valid", result_valid_o, m_done);
         check("cmp_busy", busy_o, m_busy || m_done);
         if (m_done) begin
            check("cmp_result", result_o, m_res);
            check("cmp_trans_id", result_trans_id_o, m_tid);
         end
      end
   end

   // Issue one op from an idle DUT (called #1 after an edge) and check it
   task automatic run_op(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic [TRANS_ID_BITS-1:0] tid, input logic [63:0] exp_res,
                         input int exp_lat);
      int lat;
      fu_data_i   = '{operation: op, operand_a: a, operand_b: b, trans_id: tid};
      bmu_valid_i = 1'b1;
      @(posedge clk_i); #1;
      bmu_valid_i = 1'b0;
      lat = 1;
      while (!result_valid_o && lat < 200) begin
         @(posedge clk_i); #1;
         lat++;
      end
      check("latency", 64'(lat), 64'(exp_lat));
      check("result", result_o, exp_res);
      check("trans_id", result_trans_id_o, tid);
      check("ready_in_done", bmu_ready_o, 1'b0);
      if (result_ready_i) begin
         @(posedge clk_i); #1;
         check("ready_after_done", bmu_ready_o, 1'b1);
         check("valid_after_done", result_valid_o, 1'b0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, bmu_ready_o, 1'b1);
      check({tag, "_valid"}, result_valid_o, 1'b0);
      check({tag, "_busy"}, busy_o, 1'b0);
      check({tag, "_result"}, result_o, 64'd0);
      check({tag, "_trans_id"}, result_trans_id_o, 3'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      check_reset_outputs("reset");
      chk_en = 1'b1;
      rst_i  = 1'b0;

      // pin the model against hand-computed values
      check("model_bext", model_result(BEXT, 64'hF0, 64'hAA), 64'hC);
      check("model_bdep", model_result(BDEP, 64'h3, 64'h50), 64'h50);
      check("model_bdep2", model_result(BDEP, 64'hA5, 64'hF0F0), 64'hA050);

      run_op(BEXT, 64'hF0, 64'hAA, 3'd1, 64'hC, 5);
      run_op(BDEP, 64'h3, 64'h50, 3'd2, 64'h50, 3);
      run_op(BDEP, 64'hA5, 64'hF0F0, 3'd3, 64'hA050, 9);
      run_op(BEXT, 64'h1234_5678, 64'd0, 3'd3, 64'd0, 1);
      run_op(ADD, 64'h1234_5678, 64'hFF, 3'd4, 64'd0, 1);
      run_op(BEXT, 64'hDEADBEEF_01234567, 64'hFFFF_FFFF_FFFF_FFFF, 3'd5,
             64'hDEADBEEF_01234567, 65);
      run_op(BDEP, 64'hDEADBEEF_01234567, 64'hFFFF_FFFF_FFFF_FFFF, 3'd6,
             64'hDEADBEEF_01234567, 65);

      // backpressure: DONE held for three cycles
      result_ready_i = 1'b0;
      run_op(BEXT, 64'hF0, 64'hAA, 3'd7, 64'hC, 5);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
         check("bp_result", result_o, 64'hC);
         check("bp_trans_id", result_trans_id_o, 3'd7);
         check("bp_ready", bmu_ready_o, 1'b0);
         check("bp_valid", result_valid_o, 1'b1);
      end
      result_ready_i = 1'b1;
      @(posedge clk_i); #1;
      check("bp_release_ready", bmu_ready_o, 1'b1);
      check("bp_release_valid", result_valid_o, 1'b0);
      run_op(BDEP, 64'h3, 64'h50, 3'd0, 64'h50, 3);

      // flush in the second BUSY cycle
      fu_data_i   = '{operation: BDEP, operand_a: 64'h5A, operand_b: 64'hFF, trans_id: 3'd1};
      bmu_valid_i = 1'b1;
      @(posedge clk_i); #1;
      bmu_valid_i = 1'b0;
      @(posedge clk_i); #1;
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      check("flush_ready", bmu_ready_o, 1'b1);
      check("flush_valid", result_valid_o, 1'b0);
      check("flush_busy", busy_o, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         check("flush_no_result", result_valid_o, 1'b0);
      end

      // flush coincident with an issue in IDLE
      fu_data_i   = '{operation: BEXT, operand_a: 64'hF0, operand_b: 64'd0, trans_id: 3'd2};
      bmu_valid_i = 1'b1;
      flush_i     = 1'b1;
      @(posedge clk_i); #1;
      bmu_valid_i = 1'b0;
      flush_i     = 1'b0;
      check("flush_issue_ready", bmu_ready_o, 1'b1);
      check("flush_issue_busy", busy_o, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
         check("flush_issue_no_result", result_valid_o, 1'b0);
      end

      // reset in the middle of BUSY
      fu_data_i   = '{operation: BEXT, operand_a: 64'hDEADBEEF_01234567,
                      operand_b: 64'hFFFF_FFFF_FFFF_FFFF, trans_id: 3'd5};
      bmu_valid_i = 1'b1;
      @(posedge clk_i); #1;
      bmu_valid_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #1;
      check("pre_reset_busy", busy_o, 1'b1);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      check_reset_outputs("mid_reset");

      run_op(BEXT, 64'hF0, 64'hAA, 3'd2, 64'hC, 5);

      @(posedge clk_i); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
